// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the seven-segment display controller.
// Segment patterns are active-low, bit order g..a (bit 0 = segment a).
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'h7F;

    localparam seg7_t SEG7_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Load/display bundle between the status-register side and the HEX pin driver.
// master drives the capture inputs; slave is the display controller.
interface seg7_display_ctrl_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] hex_data;
    logic                load;
    logic                lz_en;
    logic [DIGITS-1:0]   digit_en;
    logic [DIGITS-1:0]   blink_mask;
    logic [7*DIGITS-1:0] seg_out;
    logic                load_ack;
    logic                blink_phase;

    modport master (
        output hex_data, load, lz_en, digit_en, blink_mask,
        input  seg_out, load_ack, blink_phase
    );

    modport slave (
        input  hex_data, load, lz_en, digit_en, blink_mask,
        output seg_out, load_ack, blink_phase
    );
endinterface

// File: rtl/seg7_glyph.sv
// Combinational nibble to active-low seven-segment glyph decode.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);
    assign seg = SEG7_GLYPH[nibble];
endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment controller: shadow capture on load, leading-zero
// suppression, per-digit enable and blink. Blinking is built only with SEG7_BLINK_EN.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int BLINK_DIV = 25_000_000,
    parameter int LZ_MIN    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    seg7_display_ctrl_if.slave bus
);

    logic [4*DIGITS-1:0] data_reg;
    logic                lz_reg;
    logic [DIGITS-1:0]   en_reg;
    logic                ack_reg;
    logic [7*DIGITS-1:0] seg_reg;
    logic [7*DIGITS-1:0] seg_next;
    logic [DIGITS-1:0]   blink_dark;
    logic [DIGITS-1:0]   blank_vec;
    logic                phase_reg;
    logic                zero_run;
    seg7_t               glyph [DIGITS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= '0;
            lz_reg   <= 1'b0;
            en_reg   <= '0;
            ack_reg  <= 1'b0;
            seg_reg  <= '1;
        end else begin
            ack_reg <= bus.load;
            seg_reg <= seg_next;
            if (bus.load) begin
                data_reg <= bus.hex_data;
                lz_reg   <= bus.lz_en;
                en_reg   <= bus.digit_en;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0]  cnt_reg;
    logic [DIGITS-1:0] mask_reg;

    // Free-running half-period counter; load never disturbs the blink cadence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
            mask_reg  <= '0;
        end else begin
            if (bus.load) begin
                mask_reg <= bus.blink_mask;
            end
            if (cnt_reg == CNT_W'(BLINK_DIV - 1)) begin
                cnt_reg   <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign blink_dark = mask_reg & {DIGITS{phase_reg}};
`else
    logic unused_blink_mask;

    assign phase_reg         = 1'b0;
    assign blink_dark        = '0;
    assign unused_blink_mask = ^bus.blink_mask;
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            seg7_glyph u_glyph (
                .nibble (data_reg[4*gi +: 4]),
                .seg    (glyph[gi])
            );
        end
    endgenerate

    // Walk from the top digit down so zero_run means "this nibble and all above are zero".
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        seg_next  = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (data_reg[4*i +: 4] == 4'h0);
            blank_vec[i] = !en_reg[i] || (lz_reg && (i >= LZ_MIN) && zero_run) || blink_dark[i];
            seg_next[7*i +: 7] = blank_vec[i] ? SEG7_BLANK : glyph[i];
        end
    end

    assign bus.seg_out     = seg_reg;
    assign bus.load_ack    = ack_reg;
    assign bus.blink_phase = phase_reg;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench for seg7_display_ctrl (DIGITS=8, BLINK_DIV=4, LZ_MIN=1);
// honours SEG7_BLINK_EN for the expected blink behaviour.
module tb_seg7_display_ctrl;

    localparam int DIGITS    = 8;
    localparam int BLINK_DIV = 4;
    localparam int LZ_MIN    = 1;
`ifdef SEG7_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif
    localparam logic [55:0] ALL_DARK = 56'hFF_FFFF_FFFF_FFFF;

    logic clk;
    logic reset_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   edge_cnt;
    bit   ack_seen = 1'b0;

    logic [55:0] exp_q [$];

    logic [31:0] sh_data;
    logic        sh_lz;
    logic [7:0]  sh_en;
    logic [7:0]  sh_mask;

    logic [6:0] tb_glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_display_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seg7_display_ctrl #(
        .DIGITS    (DIGITS),
        .BLINK_DIV (BLINK_DIV),
        .LZ_MIN    (LZ_MIN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges since reset was released.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    // Blink phase as it stands after edge n: toggles every BLINK_DIV edges.
    function automatic logic phase_after(input int n);
        return BLINK_ON ? logic'((n / BLINK_DIV) % 2) : 1'b0;
    endfunction

    function automatic logic [55:0] model_seg(input logic [31:0] d, input logic lz,
                                              input logic [7:0] en, input logic [7:0] mask,
                                              input logic ph);
        logic [55:0] res;
        logic        blank;
        logic        upper_zero;
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            upper_zero = ((d >> (4 * i)) == 32'd0);
            blank = !en[i] || (lz && (i >= LZ_MIN) && upper_zero) || (BLINK_ON && mask[i] && ph);
            res[7*i +: 7] = blank ? 7'h7F : tb_glyph[d[4*i +: 4]];
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive at a negedge so the capture happens at the following posedge (edge k).
    task automatic drive_and_push(input logic [31:0] d, input logic lz,
                                  input logic [7:0] en, input logic [7:0] mask);
        bus.hex_data   = d;
        bus.lz_en      = lz;
        bus.digit_en   = en;
        bus.blink_mask = mask;
        bus.load       = 1'b1;
        sh_data = d;
        sh_lz   = lz;
        sh_en   = en;
        sh_mask = mask;
        exp_q.push_back(model_seg(d, lz, en, mask, phase_after(edge_cnt + 1)));
        $display("load data=%h lz=%0b en=%h mask=%h edge=%0d", d, lz, en, mask, edge_cnt + 1);
    endtask

    task automatic do_load(input logic [31:0] d, input logic lz,
                           input logic [7:0] en, input logic [7:0] mask);
        @(negedge clk);
        drive_and_push(d, lz, en, mask);
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_data();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 32'd0 : ($urandom >> (4 * r));
    endfunction

    // Monitor: the cycle after load_ack, seg_out must match the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (ack_seen) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL ack_unexpected: got load_ack=1 expected no pending load");
                end else begin
                    check("load_seg", bus.seg_out, exp_q.pop_front());
                end
            end
            ack_seen = bus.load_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n        = 1'b1;
        bus.load       = 1'b0;
        bus.hex_data   = '0;
        bus.lz_en      = 1'b0;
        bus.digit_en   = '0;
        bus.blink_mask = '0;
        sh_data = '0; sh_lz = 1'b0; sh_en = '0; sh_mask = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_seg", bus.seg_out, ALL_DARK);
        check("reset_ack", 56'(bus.load_ack), 56'd0);
        check("reset_phase", 56'(bus.blink_phase), 56'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("dark_before_load", bus.seg_out, ALL_DARK);

        do_load(32'h0000_00A5, 1'b1, 8'hFF, 8'h00);
        do_load(32'h0000_00A5, 1'b0, 8'hFF, 8'h00);
        do_load(32'h0000_0000, 1'b1, 8'hFF, 8'h00);
        do_load(32'h1234_5678, 1'b0, 8'h0F, 8'h00);
        drain();

        bus.hex_data = $urandom;
        bus.lz_en    = 1'b1;
        bus.digit_en = 8'hF0;
        repeat (3) @(negedge clk);
        check("stale_input", bus.seg_out, model_seg(sh_data, sh_lz, sh_en, sh_mask, phase_after(edge_cnt - 1)));

        do_load(32'h1234_5678, 1'b0, 8'hFF, 8'h01);
        drain();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("blink_phase", 56'(bus.blink_phase), 56'(phase_after(edge_cnt)));
            check("blink_seg", bus.seg_out, model_seg(sh_data, sh_lz, sh_en, sh_mask, phase_after(edge_cnt - 1)));
        end

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_and_push(rand_data(), 1'($urandom), 8'($urandom), 8'($urandom));
        end
        @(negedge clk);
        bus.load = 1'b0;
        drain();

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_load(rand_data(), 1'($urandom), 8'($urandom), 8'($urandom));
        end
        drain();

        do_load(32'h00AB_CDEF, 1'b1, 8'hFF, 8'h00);
        drain();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrun_reset_seg", bus.seg_out, ALL_DARK);
        check("midrun_reset_ack", 56'(bus.load_ack), 56'd0);
        check("midrun_reset_phase", 56'(bus.blink_phase), 56'd0);
        exp_q.delete();
        sh_data = '0; sh_lz = 1'b0; sh_en = '0; sh_mask = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("dark_after_reset", bus.seg_out, ALL_DARK);

        do_load(32'h0000_0F00, 1'b1, 8'hFF, 8'h00);
        drain();

        chk_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
